// File: rtl/npu_instr_decode_queue.sv
// rtl/npu_instr_decode_queue.sv - pipelined NPU instruction decoder with decoded-bundle FIFO
module npu_instr_decode_queue #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 20,
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [31:0]              in_instr,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_opcode,
    output logic [1:0]               out_fmt,
    output logic [3:0]               out_dest,
    output logic [3:0]               out_src_a,
    output logic [3:0]               out_src_b,
    output logic [DATA_WIDTH-1:0]    out_imm,
    output logic [ADDR_WIDTH-1:0]    out_addr,
    output logic                     out_illegal,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [7:0]               err_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_M = 2'd2;
    localparam logic [1:0] FMT_N = 2'd3;

    typedef struct packed {
        logic [3:0]            opcode;
        logic [1:0]            fmt;
        logic [3:0]            dest;
        logic [3:0]            src_a;
        logic [3:0]            src_b;
        logic [DATA_WIDTH-1:0] imm;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  illegal;
        logic [TAG_WIDTH-1:0]  tag;
    } bundle_t;

    bundle_t              r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [TAG_WIDTH-1:0] r_tag;
    logic [7:0]           r_err;

    bundle_t              w_dec;
    bundle_t              w_head;
    logic                 w_push;
    logic                 w_pop;

    // Handshakes depend only on registered occupancy, never on out_ready.
    assign in_ready  = (r_count < CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Combinational decode: keep only the fields the format actually uses.
    always_comb begin
        w_dec        = '0;
        w_dec.opcode = in_instr[31:28];
        w_dec.tag    = r_tag;
        case (in_instr[31:28])
            4'd0, 4'd9: begin
                w_dec.fmt = FMT_N;
            end
            4'd1, 4'd2: begin
                w_dec.fmt   = FMT_M;
                w_dec.dest  = in_instr[27:24];
                w_dec.src_a = in_instr[23:20];
                w_dec.addr  = in_instr[ADDR_WIDTH-1:0];
            end
            4'd3, 4'd4, 4'd5: begin
                w_dec.fmt   = FMT_R;
                w_dec.dest  = in_instr[27:24];
                w_dec.src_a = in_instr[23:20];
                w_dec.src_b = in_instr[19:16];
            end
            4'd6: begin
                // RELU is unary: src_b carries no meaning
                w_dec.fmt   = FMT_R;
                w_dec.dest  = in_instr[27:24];
                w_dec.src_a = in_instr[23:20];
            end
            4'd7, 4'd8: begin
                w_dec.fmt   = FMT_I;
                w_dec.dest  = in_instr[27:24];
                w_dec.src_a = in_instr[23:20];
                w_dec.imm   = DATA_WIDTH'($signed(in_instr[15:0]));
            end
            default: begin
                w_dec.fmt     = FMT_N;
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    // Tag and error counter advance on every accept, including one dropped by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag <= '0;
            r_err <= '0;
        end else if (w_push) begin
            r_tag <= r_tag + TAG_WIDTH'(1);
            if (w_dec.illegal && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
        end
    end

    // FIFO pointers and occupancy; flush wins over same-cycle push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Bundle storage; cleared on reset so the head reads as all-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= w_dec;
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign out_opcode  = w_head.opcode;
    assign out_fmt     = w_head.fmt;
    assign out_dest    = w_head.dest;
    assign out_src_a   = w_head.src_a;
    assign out_src_b   = w_head.src_b;
    assign out_imm     = w_head.imm;
    assign out_addr    = w_head.addr;
    assign out_illegal = w_head.illegal;
    assign out_tag     = w_head.tag;
    assign occupancy   = r_count;
    assign err_count   = r_err;

endmodule

// File: tb/tb_npu_instr_decode_queue.sv
// tb/tb_npu_instr_decode_queue.sv - scoreboard testbench for npu_instr_decode_queue
module tb_npu_instr_decode_queue;

    localparam int DW = 16;
    localparam int AW = 20;
    localparam int DEPTH = 4;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [31:0]   in_instr;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_opcode;
    logic [1:0]    out_fmt;
    logic [3:0]    out_dest;
    logic [3:0]    out_src_a;
    logic [3:0]    out_src_b;
    logic [DW-1:0] out_imm;
    logic [AW-1:0] out_addr;
    logic          out_illegal;
    logic [TW-1:0] out_tag;
    logic [2:0]    occupancy;
    logic [7:0]    err_count;

    npu_instr_decode_queue #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_fmt(out_fmt), .out_dest(out_dest),
        .out_src_a(out_src_a), .out_src_b(out_src_b), .out_imm(out_imm),
        .out_addr(out_addr), .out_illegal(out_illegal), .out_tag(out_tag),
        .occupancy(occupancy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    op;
        logic [1:0]    fmt;
        logic [3:0]    dest;
        logic [3:0]    sa;
        logic [3:0]    sb;
        logic [DW-1:0] imm;
        logic [AW-1:0] addr;
        logic          ill;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          m_exp;
    exp_t          m_got;
    int            n_checks = 0;
    int            n_fail = 0;
    int            n_pops = 0;
    logic [TW-1:0] m_tag = '0;
    logic [7:0]    m_err = '0;

    function automatic exp_t model(input logic [31:0] ins, input logic [TW-1:0] t);
        exp_t e;
        e     = '0;
        e.op  = ins[31:28];
        e.tag = t;
        case (ins[31:28])
            4'd0, 4'd9: e.fmt = 2'd3;
            4'd1, 4'd2: begin
                e.fmt = 2'd2; e.dest = ins[27:24]; e.sa = ins[23:20]; e.addr = ins[19:0];
            end
            4'd3, 4'd4, 4'd5: begin
                e.fmt = 2'd0; e.dest = ins[27:24]; e.sa = ins[23:20]; e.sb = ins[19:16];
            end
            4'd6: begin
                e.fmt = 2'd0; e.dest = ins[27:24]; e.sa = ins[23:20];
            end
            4'd7, 4'd8: begin
                e.fmt = 2'd1; e.dest = ins[27:24]; e.sa = ins[23:20]; e.imm = ins[15:0];
            end
            default: begin
                e.fmt = 2'd3; e.ill = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Scoreboard: push expected bundles on accept, compare on pop
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (flush) begin
                sb_q.delete();
            end else if (out_valid && out_ready) begin
                n_checks++;
                m_got = {out_opcode, out_fmt, out_dest, out_src_a, out_src_b,
                         out_imm, out_addr, out_illegal, out_tag};
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_pop: got %h, required no output", m_got);
                end else begin
                    m_exp = sb_q.pop_front();
                    n_pops++;
                    if (m_got !== m_exp) begin
                        n_fail++;
                        $display("FAIL sb_bundle: got %h, required %h", m_got, m_exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (!flush) sb_q.push_back(model(in_instr, m_tag));
                if (in_instr[31:28] >= 4'd10 && m_err != 8'hFF) m_err = m_err + 8'd1;
                m_tag = m_tag + 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] ins);
        in_instr = ins;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
        #3;
        sb_q.delete();
        m_tag = '0;
        m_err = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int max_cycles);
        int k = 0;
        out_ready = 1'b1;
        while (occupancy != 0 && k < max_cycles) begin
            tick();
            k++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (occupancy !== 3'd0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: occupancy %0d queue %0d, required 0", occupancy, sb_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
        #3;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: in_ready %b out_valid %b, required 1 0", in_ready, out_valid);
        end
        n_checks++;
        if (occupancy !== 3'd0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_counts: occ %0d err %0d, required 0 0", occupancy, err_count);
        end
        n_checks++;
        if ({out_opcode, out_fmt, out_dest, out_src_a, out_src_b, out_imm, out_addr, out_illegal, out_tag} !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: opcode %h tag %h imm %h, required all 0", out_opcode, out_tag, out_imm);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        do_reset();
        push_one(32'h3123_0000);
        n_checks++;
        if (out_valid !== 1'b1 || {out_opcode, out_fmt, out_dest, out_src_a, out_src_b} !== {4'd3, 2'd0, 4'd1, 4'd2, 4'd3}) begin
            n_fail++;
            $display("FAIL matmul_fields: v %b op %0d fmt %0d d %0d a %0d b %0d, required 1 3 0 1 2 3",
                     out_valid, out_opcode, out_fmt, out_dest, out_src_a, out_src_b);
        end
        n_checks++;
        if (out_imm !== 16'h0 || out_addr !== 20'h0 || out_tag !== 8'd0) begin
            n_fail++;
            $display("FAIL matmul_zero: imm %h addr %h tag %0d, required 0 0 0", out_imm, out_addr, out_tag);
        end
        drain(4);
        push_one(32'h8450_FFFE);
        n_checks++;
        if ({out_fmt, out_dest, out_src_a, out_src_b} !== {2'd1, 4'd4, 4'd5, 4'd0} || out_imm !== 16'hFFFE || out_addr !== 20'h0) begin
            n_fail++;
            $display("FAIL addi_fields: fmt %0d d %0d a %0d b %0d imm %h addr %h, required 1 4 5 0 fffe 0",
                     out_fmt, out_dest, out_src_a, out_src_b, out_imm, out_addr);
        end
        drain(4);
        push_one(32'h1700_1234);
        n_checks++;
        if (out_fmt !== 2'd2 || out_dest !== 4'd7 || out_addr !== 20'h01234 || out_imm !== 16'h0 || out_src_b !== 4'd0) begin
            n_fail++;
            $display("FAIL load_fields: fmt %0d d %0d addr %h imm %h b %0d, required 2 7 01234 0 0",
                     out_fmt, out_dest, out_addr, out_imm, out_src_b);
        end
        drain(4);
    endtask

    task automatic test_backpressure();
        logic [31:0] prog [4];
        bit accepted;
        int k;
        prog[0] = 32'h5A12_3456; prog[1] = 32'h2B00_00FF;
        prog[2] = 32'h7C10_8001; prog[3] = 32'h6FFF_FFFF;
        do_reset();
        for (int i = 0; i < 4; i++) push_one(prog[i]);
        n_checks++;
        if (in_ready !== 1'b0 || occupancy !== 3'd4) begin
            n_fail++;
            $display("FAIL full_state: in_ready %b occ %0d, required 0 4", in_ready, occupancy);
        end
        in_instr = 32'h4321_0000;
        in_valid = 1'b1;
        tick();
        tick();
        n_checks++;
        if (occupancy !== 3'd4 || out_tag !== 8'd0) begin
            n_fail++;
            $display("FAIL full_hold: occ %0d head tag %0d, required 4 0", occupancy, out_tag);
        end
        out_ready = 1'b1;
        accepted = 1'b0;
        k = 0;
        while (!accepted && k < 10) begin
            accepted = in_ready;
            tick();
            k++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!accepted) begin
            n_fail++;
            $display("FAIL fifth_accept: accepted %b, required 1", accepted);
        end
        drain(10);
        n_checks++;
        if (n_pops != 8) begin
            n_fail++;
            $display("FAIL pop_total: pops %0d, required 8", n_pops);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        push_one(32'hF123_4567);
        n_checks++;
        if (out_illegal !== 1'b1 || out_fmt !== 2'd3 || out_dest !== 4'd0 || out_addr !== 20'h0 || err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL illegal_one: ill %b fmt %0d d %0d addr %h err %0d, required 1 3 0 0 1",
                     out_illegal, out_fmt, out_dest, out_addr, err_count);
        end
        drain(4);
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_instr = {4'(10 + (i % 6)), 28'($urandom)};
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (err_count !== 8'd255) begin
            n_fail++;
            $display("FAIL err_saturate: err %0d, required 255", err_count);
        end
        drain(4);
    endtask

    task automatic test_stream();
        int bad = 0;
        int p0;
        p0 = n_pops;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_instr = {4'($urandom_range(0, 9)), 28'($urandom)};
            tick();
            if (!(out_valid === 1'b1 && occupancy <= 3'd1 && in_ready === 1'b1)) bad++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stream_rate: %0d stalled cycles, required 0", bad);
        end
        drain(4);
        n_checks++;
        if (n_pops - p0 != 300) begin
            n_fail++;
            $display("FAIL stream_count: pops %0d, required 300", n_pops - p0);
        end
    endtask

    task automatic test_flush();
        logic [TW-1:0] base;
        base = m_tag;
        out_ready = 1'b0;
        push_one(32'h5111_0000);
        push_one(32'h8222_0010);
        push_one(32'h2333_4444);
        n_checks++;
        if (occupancy !== 3'd3) begin
            n_fail++;
            $display("FAIL flush_pre: occ %0d, required 3", occupancy);
        end
        flush = 1'b1;
        out_ready = 1'b1;
        in_instr = 32'h9000_0000;
        in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (occupancy !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_empty: occ %0d valid %b, required 0 0", occupancy, out_valid);
        end
        push_one(32'h4abc_0000);
        n_checks++;
        if (out_tag !== TW'(base + 8'd4) || occupancy !== 3'd1) begin
            n_fail++;
            $display("FAIL flush_tag: tag %0d occ %0d, required %0d 1", out_tag, occupancy, TW'(base + 8'd4));
        end
        drain(4);
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        push_one(32'h3111_0000);
        push_one(32'h3222_0000);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (occupancy !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_tag !== 8'd0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: occ %0d valid %b ready %b tag %0d err %0d, required 0 0 1 0 0",
                     occupancy, out_valid, in_ready, out_tag, err_count);
        end
        sb_q.delete();
        m_tag = '0;
        m_err = '0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_illegal();
        test_stream();
        test_flush();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/npu_instr_decode_queue.md
# npu_instr_decode_queue

Parametrised, fully pipelined instruction decoder for the NPU control path. It accepts one 32-bit instruction per cycle over a valid/ready handshake and decodes it into a format-aware field bundle with legality checking and a sequence tag. Decoded bundles are buffered in a DEPTH-entry FIFO ahead of the dispatch logic. It sits between the instruction fetch unit and the execution dispatcher, and supersedes the single-shot, three-state decoder.

## Interface
- DATA_WIDTH, 16: width of the sign-extended immediate output
- ADDR_WIDTH, 20: width of the address output; legal range 1..24
- DEPTH, 4: decoded-bundle FIFO entries; power of two, ≥2
- TAG_WIDTH, 8: sequence tag width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous flush of queued bundles
- in_instr  in  32  instruction word
- in_valid  in  1  instruction present
- in_ready  out  1  decoder can accept
- out_valid  out  1  head bundle valid
- out_ready  in  1  dispatcher consumes head
- out_opcode  out  4  opcode
- out_fmt  out  2  0=R, 1=I, 2=M, 3=N (no operands)
- out_dest, out_src_a, out_src_b  out  4 each  register indices
- out_imm  out  DATA_WIDTH  sign-extended instr[15:0]
- out_addr  out  ADDR_WIDTH  instr[ADDR_WIDTH-1:0], zero-extended
- out_illegal  out  1  opcode undefined
- out_tag  out  TAG_WIDTH  sequence tag of bundle
- occupancy  out  $clog2(DEPTH)+1  queued entry count
- err_count  out  8  saturating count of accepted illegal instructions

## Operation
- Fields: opcode=[31:28], dest=[27:24], src_a=[23:20], src_b=[19:16], imm=[15:0], addr=[ADDR_WIDTH-1:0].
- Opcode map: 0 NOP(N), 1 LOAD(M), 2 STORE(M), 3 MATMUL(R), 4 CONV(R), 5 ADD(R), 6 RELU(R), 7 POOL(I), 8 ADDI(I), 9 SYNC(N), 10–15 illegal (fmt=N, illegal=1).
- Unused fields per format are forced to 0: N zeroes dest/src/imm/addr; M zeroes src_b and imm; I zeroes src_b and addr; R zeroes imm and addr. RELU additionally zeroes src_b.
- imm: sign-extended from bit 15 to DATA_WIDTH; truncated to [DATA_WIDTH-1:0] when DATA_WIDTH<16.
- Accept = in_valid && in_ready; decode is combinational on in_instr and is written into the FIFO at tail on accept.
- Tag counter starts at 0, is stamped on each accepted bundle, then increments, wrapping at 2^TAG_WIDTH. Flush does not reset it.
- err_count increments on each accepted illegal instruction and saturates at 255. It is cleared only by reset.
- Pop = out_valid && out_ready; advances the head.
- flush: empties the FIFO (occupancy=0, pointers to 0). It has priority over a same-cycle push and pop; the same-cycle accept is dropped but still consumes a tag and updates err_count.
- Illegal instructions are queued normally; the dispatcher handles out_illegal.

## Timing
- Reset values: in_ready=1, out_valid=0, occupancy=0, err_count=0, tag=0, all out_* fields 0.
- in_ready = (occupancy < DEPTH), from registered state only. No combinational path from out_ready to in_ready.
- out_valid = (occupancy != 0). Output fields come from the head entry and are stable while out_valid && !out_ready.
- Latency: instruction accepted at edge N is visible at out_* after edge N (1 cycle); no same-cycle bypass.
- Throughput: 1 instruction/cycle sustained with out_ready held high.
- Push and pop in the same cycle: occupancy unchanged. When full, push is impossible (in_ready=0), so a pop frees a slot for the next cycle.
- Pointers wrap modulo DEPTH.
- Async reset mid-stream discards all entries immediately.

## Test plan
- Reset, then 0x3123_0000 (MATMUL d1,a2,b3) -> next cycle out_valid=1, opcode=3, fmt=0, dest=1, src_a=2, src_b=3, imm=0, addr=0, tag=0.
- ADDI 0x8450_FFFE -> fmt=1, dest=4, src_a=5, src_b=0, imm=0xFFFE (DATA_WIDTH=16, i.e. -2); LOAD 0x1700_1234 -> fmt=2, dest=7, addr=0x01234, imm=0.
- out_ready=0 while pushing 5 instructions with DEPTH=4 -> in_ready drops after the 4th accept and occupancy=4; the 5th is held. Raising out_ready drains the entries in order with tags 0,1,2,3.
- Opcode 0xF instruction -> out_illegal=1, fmt=3, err_count=1. 300 illegal accepts -> err_count=255.
- Streaming with out_ready=1 for 300 instructions -> one output per cycle, occupancy ≤1, tags wrap 255→0.
- flush asserted with occupancy=3 and a concurrent accept -> next cycle occupancy=0, out_valid=0; the next accepted instruction carries tag = previous + 2.
